// File: rtl/onewire_pkg.sv
// onewire_pkg: shared definitions for the 1-Wire bit-level master.
// Holds the command codes, the FSM state encoding, the slot timing
// constants in microseconds, and helpers that map a command to its
// low / sample / end points.
package onewire_pkg;

  localparam logic [1:0] CMD_RESET  = 2'd0;
  localparam logic [1:0] CMD_WRITE0 = 2'd1;
  localparam logic [1:0] CMD_WRITE1 = 2'd2;
  localparam logic [1:0] CMD_READ   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOW     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [9:0] US_RST_LOW    = 10'd480;
  localparam logic [9:0] US_RST_SAMPLE = 10'd550;
  localparam logic [9:0] US_RST_END    = 10'd960;
  localparam logic [9:0] US_SHORT_LOW  = 10'd6;
  localparam logic [9:0] US_SAMPLE     = 10'd15;
  localparam logic [9:0] US_W0_LOW     = 10'd60;
  localparam logic [9:0] US_SLOT_END   = 10'd70;

  function automatic logic [9:0] low_us(input logic [1:0] cmd);
    case (cmd)
      CMD_RESET:  low_us = US_RST_LOW;
      CMD_WRITE0: low_us = US_W0_LOW;
      default:    low_us = US_SHORT_LOW;
    endcase
  endfunction

  // WRITE0 never samples; its value is unused.
  function automatic logic [9:0] sample_us(input logic [1:0] cmd);
    sample_us = (cmd == CMD_RESET) ? US_RST_SAMPLE : US_SAMPLE;
  endfunction

  function automatic logic [9:0] end_us(input logic [1:0] cmd);
    end_us = (cmd == CMD_RESET) ? US_RST_END : US_SLOT_END;
  endfunction

endpackage

// File: rtl/onewire_tick.sv
// onewire_tick: microsecond prescaler.
// Ports:
//   clk_i     - clock
//   rst_i     - synchronous active-high reset
//   restart_i - forces the count back to 0 on the next edge
//   tick_o    - high for the last cycle of each microsecond (count wraps)
module onewire_tick #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [9:0] LAST = 10'(CLK_PER_US - 1);

  logic [9:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 10'd1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/onewire_master.sv
// onewire_master: bit-level 1-Wire master driving an open-drain pad buffer.
// Ports:
//   C, R                 - clock, synchronous active-high reset
//   CMD_VALID/READY, CMD - single-slot command handshake (RESET/WRITE0/WRITE1/READ)
//   RSP_VALID            - one-cycle pulse at the end of each slot
//   RSP_BIT, PRESENCE    - sampled bit (READ/WRITE1), presence (RESET)
//   PAD_I, PAD_T, PAD_O  - tri-state buffer pins; PAD_T=0 pulls the line low
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | line released, ready for a command
// ST_LOW     | line pulled low for the command's low duration
// ST_RELEASE | line released, sample at sample point, wait slot end
// ST_DONE    | RSP_VALID pulse, back to idle next cycle
module onewire_master
  import onewire_pkg::*;
#(
  parameter int CLK_PER_US = 50
) (
  input  logic       C,
  input  logic       R,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD,
  output logic       RSP_VALID,
  output logic       RSP_BIT,
  output logic       PRESENCE,
  output logic       PAD_I,
  output logic       PAD_T,
  input  logic       PAD_O
);

  state_e     state_q;
  logic [1:0] cmd_q;
  logic [9:0] us_q;
  logic [1:0] sync_q;
  logic       pad_t_q, cmd_ready_q, rsp_valid_q, rsp_bit_q, presence_q;
  logic       tick, accept;

  assign accept = (state_q == ST_IDLE) && CMD_VALID;

  onewire_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk_i    (C),
    .rst_i    (R),
    .restart_i(accept),
    .tick_o   (tick)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_RESET;
      us_q        <= '0;
      sync_q      <= 2'b11;
      pad_t_q     <= 1'b1;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      presence_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], PAD_O};
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pad_t_q <= 1'b1;
          if (accept) begin
            cmd_q       <= CMD;
            us_q        <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (tick) us_q <= us_q + 10'd1;
          // us_q reaches the low duration exactly low*CLK_PER_US cycles
          // after acceptance, so the release lands one edge later.
          if (us_q >= low_us(cmd_q)) begin
            pad_t_q <= 1'b1;
            state_q <= ST_RELEASE;
          end else begin
            pad_t_q <= 1'b0;
          end
        end
        ST_RELEASE: begin
          pad_t_q <= 1'b1;
          if (tick) us_q <= us_q + 10'd1;
          // Sample on the edge where the us count steps onto the sample point.
          if (tick && (us_q + 10'd1 == sample_us(cmd_q)) && (cmd_q != CMD_WRITE0)) begin
            if (cmd_q == CMD_RESET) presence_q <= ~sync_q[1];
            else                    rsp_bit_q  <= sync_q[1];
          end
          if (us_q == end_us(cmd_q)) begin
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
            if ((cmd_q == CMD_RESET) || (cmd_q == CMD_WRITE0)) rsp_bit_q <= 1'b0;
          end
        end
        ST_DONE: begin
          pad_t_q     <= 1'b1;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_BIT   = rsp_bit_q;
  assign PRESENCE  = presence_q;
  assign PAD_I     = 1'b0;
  assign PAD_T     = pad_t_q;

endmodule
